// File: rtl/vegeta_tiled_control_if.sv
// Handshake bundle between the VEGETA tiled controller and the blocks it drives.
// The controller takes the slave side; whatever drives jobs and ready pulses takes the master side.
interface vegeta_tiled_control_if #(
  parameter int MAX_TILES = 8
);
  localparam int NT_W = $clog2(MAX_TILES + 1);
  localparam int TI_W = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

  logic            start_multiplication;
  logic [NT_W-1:0] num_tiles;
  logic            abort;
  logic            weight_array_loaded;
  logic            activation_L1_loaded;
  logic            accumulation_L1_loaded;
  logic            output_L2_loaded;

  logic            begin_load;
  logic            start_compute;
  logic            mode;
  logic            output_valid;
  logic [TI_W-1:0] tile_idx;
  logic            busy;
  logic            compute_done;
  logic            error;

  modport slave (
    input  start_multiplication, num_tiles, abort,
    input  weight_array_loaded, activation_L1_loaded, accumulation_L1_loaded,
    input  output_L2_loaded,
    output begin_load, start_compute, mode, output_valid,
    output tile_idx, busy, compute_done, error
  );

  modport master (
    output start_multiplication, num_tiles, abort,
    output weight_array_loaded, activation_L1_loaded, accumulation_L1_loaded,
    output output_L2_loaded,
    input  begin_load, start_compute, mode, output_valid,
    input  tile_idx, busy, compute_done, error
  );
endinterface

// File: rtl/vegeta_tiled_control.sv
// VEGETA top-level controller: walks a programmable number of weight tiles through
// LOAD -> SYNC -> FLOW -> DRAIN -> WRITE, with abort, wait-phase timeout and status.
module vegeta_tiled_control #(
  parameter int K_SCALED  = 4,
  parameter int M_SCALED  = 4,
  parameter int N         = 4,
  parameter int MAX_TILES = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vegeta_tiled_control_if.slave  bus
);

  localparam int NT_W    = $clog2(MAX_TILES + 1);
  localparam int TI_W    = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;
  localparam int FLOW_W  = $clog2(K_SCALED + 2) + 1;
  localparam int DRAIN_W = $clog2(N + M_SCALED + 1) + 1;
  localparam int WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [FLOW_W-1:0]  FLOW_LAST  = FLOW_W'(K_SCALED);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(N + M_SCALED - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NT_W-1:0]    NT_MAX     = NT_W'(MAX_TILES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SYNC,
    S_FLOW,
    S_DRAIN,
    S_WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [FLOW_W-1:0]   flow_cnt_q, flow_cnt_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [2:0]          ready_q, ready_d;
  logic [NT_W-1:0]     num_tiles_q, num_tiles_d;
  logic [TI_W-1:0]     tile_idx_q, tile_idx_d;
  logic                compute_done_q, compute_done_d;
  logic                error_q, error_d;

  logic                begin_load_q, begin_load_d;
  logic                start_compute_q, start_compute_d;
  logic                mode_q, mode_d;
  logic                output_valid_q, output_valid_d;
  logic                busy_q, busy_d;

  logic [2:0]          pulses;
  logic                all_ready;
  logic                start_ok;
  logic                timeout_hit;
  logic                last_tile;

  // Bit order {C, A, W}; a pulse in the same cycle as the last sticky flag still counts.
  assign pulses      = {bus.accumulation_L1_loaded, bus.activation_L1_loaded,
                        bus.weight_array_loaded};
  assign all_ready   = &(ready_q | pulses);
  assign start_ok    = bus.start_multiplication && (bus.num_tiles != '0)
                       && (bus.num_tiles <= NT_MAX);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);
  assign last_tile   = (NT_W'(tile_idx_q) + NT_W'(1)) == num_tiles_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    num_tiles_d    = num_tiles_q;
    tile_idx_d     = tile_idx_q;
    compute_done_d = compute_done_q;
    error_d        = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok && !bus.abort) begin
          state_d        = S_LOAD;
          num_tiles_d    = bus.num_tiles;
          tile_idx_d     = '0;
          compute_done_d = 1'b0;
          error_d        = 1'b0;
        end
      end
      S_LOAD: begin
        if (all_ready) begin
          state_d = S_SYNC;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end
      end
      S_SYNC: state_d = S_FLOW;
      S_FLOW: begin
        if (flow_cnt_q == FLOW_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus.output_L2_loaded) begin
          if (last_tile) begin
            state_d        = S_IDLE;
            compute_done_d = 1'b1;
          end else begin
            state_d    = S_LOAD;
            tile_idx_d = tile_idx_q + TI_W'(1);
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks completion and timeout; error keeps whatever it held.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      tile_idx_d     = '0;
      compute_done_d = compute_done_q;
      error_d        = error_q;
    end

    flow_cnt_d  = (state_q == S_FLOW  && state_d == S_FLOW)  ? flow_cnt_q + FLOW_W'(1)   : '0;
    drain_cnt_d = (state_q == S_DRAIN && state_d == S_DRAIN) ? drain_cnt_q + DRAIN_W'(1) : '0;
    wait_cnt_d  = ((state_q == S_LOAD || state_q == S_WRITE) && state_d == state_q)
                  ? wait_cnt_q + WAIT_W'(1) : '0;
    ready_d     = (state_q == S_LOAD && state_d == S_LOAD) ? (ready_q | pulses) : '0;

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    begin_load_d    = (state_d == S_LOAD) && (state_q != S_LOAD);
    start_compute_d = (state_d == S_SYNC);
    mode_d          = (state_d == S_FLOW) || (state_d == S_DRAIN);
    output_valid_d  = (state_d == S_DRAIN) && (state_q != S_DRAIN);
    busy_d          = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      flow_cnt_q      <= '0;
      drain_cnt_q     <= '0;
      wait_cnt_q      <= '0;
      ready_q         <= '0;
      num_tiles_q     <= '0;
      tile_idx_q      <= '0;
      compute_done_q  <= 1'b0;
      error_q         <= 1'b0;
      begin_load_q    <= 1'b0;
      start_compute_q <= 1'b0;
      mode_q          <= 1'b0;
      output_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      flow_cnt_q      <= flow_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      ready_q         <= ready_d;
      num_tiles_q     <= num_tiles_d;
      tile_idx_q      <= tile_idx_d;
      compute_done_q  <= compute_done_d;
      error_q         <= error_d;
      begin_load_q    <= begin_load_d;
      start_compute_q <= start_compute_d;
      mode_q          <= mode_d;
      output_valid_q  <= output_valid_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.begin_load    = begin_load_q;
  assign bus.start_compute = start_compute_q;
  assign bus.mode          = mode_q;
  assign bus.output_valid  = output_valid_q;
  assign bus.tile_idx      = tile_idx_q;
  assign bus.busy          = busy_q;
  assign bus.compute_done  = compute_done_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_vegeta_tiled_control.sv
// Self-checking bench for vegeta_tiled_control: start-gating vector table, a tile-index
// scoreboard on output_valid, and directed sequences for timeout, abort and async reset.
module tb_vegeta_tiled_control;

  localparam int K_SCALED  = 4;
  localparam int M_SCALED  = 2;
  localparam int N         = 4;
  localparam int MAX_TILES = 8;
  localparam int TIMEOUT   = 16;
  localparam int NT_W      = $clog2(MAX_TILES + 1);
  localparam int MODE_RUN  = K_SCALED + 1 + N + M_SCALED;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vegeta_tiled_control_if #(.MAX_TILES(MAX_TILES)) bus();

  vegeta_tiled_control #(
    .K_SCALED (K_SCALED),
    .M_SCALED (M_SCALED),
    .N        (N),
    .MAX_TILES(MAX_TILES),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NT_W-1:0] num_tiles;
    logic            abort;
    logic            exp_accept;
  } gate_vec_t;

  gate_vec_t vecs [6];

  int checks   = 0;
  int failures = 0;
  int n_bl     = 0;
  int n_sc     = 0;
  int n_ov     = 0;
  int n_mode   = 0;
  int ov_pos   = 0;
  int exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (bus.begin_load)    n_bl++;
    if (bus.start_compute) n_sc++;
    if (bus.mode)          n_mode++;
    if (bus.output_valid) begin
      n_ov++;
      ov_pos = n_mode;
      if (exp_q.size() == 0) begin
        check("ov_expected_pending", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("ov_tile", bus.tile_idx, e);
      end
    end
  endtask

  task automatic start_job(input int nt);
    bus.num_tiles            = NT_W'(nt);
    bus.start_multiplication = 1'b1;
    tick();
    bus.start_multiplication = 1'b0;
  endtask

  task automatic abort_to_idle();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic finish_write();
    bus.output_L2_loaded = 1'b1;
    tick();
    bus.output_L2_loaded = 1'b0;
  endtask

  // From a LOAD cycle: all ready pulses at once, then run to the WRITE state.
  task automatic run_compute(input int idx);
    exp_q.push_back(idx);
    bus.weight_array_loaded    = 1'b1;
    bus.activation_L1_loaded   = 1'b1;
    bus.accumulation_L1_loaded = 1'b1;
    tick();
    bus.weight_array_loaded    = 1'b0;
    bus.activation_L1_loaded   = 1'b0;
    bus.accumulation_L1_loaded = 1'b0;
    check($sformatf("start_compute_t%0d", idx), bus.start_compute, 1);
    repeat (MODE_RUN + 1) tick();
    check($sformatf("in_write_t%0d", idx), {bus.busy, bus.mode}, 2'b10);
  endtask

  function automatic logic [9:0] all_outputs();
    return {bus.begin_load, bus.start_compute, bus.mode, bus.output_valid,
            bus.tile_idx, bus.busy, bus.compute_done, bus.error};
  endfunction

  initial begin
    int n;
    int ov_snap;

    vecs[0] = '{num_tiles: NT_W'(0),             abort: 1'b0, exp_accept: 1'b0};
    vecs[1] = '{num_tiles: NT_W'(MAX_TILES + 1), abort: 1'b0, exp_accept: 1'b0};
    vecs[2] = '{num_tiles: NT_W'(15),            abort: 1'b0, exp_accept: 1'b0};
    vecs[3] = '{num_tiles: NT_W'(1),             abort: 1'b0, exp_accept: 1'b1};
    vecs[4] = '{num_tiles: NT_W'(MAX_TILES),     abort: 1'b0, exp_accept: 1'b1};
    vecs[5] = '{num_tiles: NT_W'(3),             abort: 1'b1, exp_accept: 1'b0};

    bus.start_multiplication   = 1'b0;
    bus.num_tiles              = '0;
    bus.abort                  = 1'b0;
    bus.weight_array_loaded    = 1'b0;
    bus.activation_L1_loaded   = 1'b0;
    bus.accumulation_L1_loaded = 1'b0;
    bus.output_L2_loaded       = 1'b0;

    #2;
    check("reset_outputs", all_outputs(), 0);
    #10 rst_n = 1'b1;
    tick();
    check("idle_after_reset", all_outputs(), 0);

    // Single tile, all ready pulses in one cycle
    start_job(1);
    check("t1_begin_load", bus.begin_load, 1);
    check("t1_busy", bus.busy, 1);
    check("t1_tile_idx", bus.tile_idx, 0);
    n_mode = 0;
    ov_pos = 0;
    run_compute(0);
    check("t1_mode_cycles", n_mode, MODE_RUN);
    check("t1_ov_position", ov_pos, K_SCALED + 2);
    finish_write();
    check("t1_done_idle", {bus.compute_done, bus.busy, bus.error}, 3'b100);

    // Three tiles, staggered W / A / C pulses
    n_bl = 0; n_sc = 0; n_ov = 0;
    start_job(3);
    for (int t = 0; t < 3; t++) begin
      check($sformatf("t2_tile_idx_%0d", t), bus.tile_idx, t);
      bus.weight_array_loaded = 1'b1;
      tick();
      bus.weight_array_loaded = 1'b0;
      tick();
      tick();
      bus.activation_L1_loaded = 1'b1;
      tick();
      bus.activation_L1_loaded = 1'b0;
      tick();
      check($sformatf("t2_no_early_sc_%0d", t), bus.start_compute, 0);
      exp_q.push_back(t);
      bus.accumulation_L1_loaded = 1'b1;
      tick();
      bus.accumulation_L1_loaded = 1'b0;
      check($sformatf("t2_sc_after_c_%0d", t), bus.start_compute, 1);
      repeat (MODE_RUN + 1) tick();
      check($sformatf("t2_done_before_write_%0d", t), bus.compute_done, 0);
      finish_write();
    end
    check("t2_done_idle", {bus.compute_done, bus.busy}, 2'b10);
    check("t2_begin_load_count", n_bl, 3);
    check("t2_start_compute_count", n_sc, 3);
    check("t2_output_valid_count", n_ov, 3);

    // Timeout: C never arrives
    n_sc = 0;
    start_job(1);
    bus.weight_array_loaded  = 1'b1;
    bus.activation_L1_loaded = 1'b1;
    tick();
    bus.weight_array_loaded  = 1'b0;
    bus.activation_L1_loaded = 1'b0;
    n = 1;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    check("t3_timeout_cycles", n, TIMEOUT);
    check("t3_error_done", {bus.error, bus.compute_done, bus.busy}, 3'b100);
    check("t3_no_start_compute", n_sc, 0);
    start_job(1);
    check("t3_error_cleared", {bus.error, bus.busy}, 2'b01);
    abort_to_idle();
    check("t3_abort_idle", {bus.busy, bus.error}, 2'b00);

    // Ready completion in the very cycle the timeout would fire
    start_job(1);
    repeat (TIMEOUT - 1) tick();
    bus.weight_array_loaded    = 1'b1;
    bus.activation_L1_loaded   = 1'b1;
    bus.accumulation_L1_loaded = 1'b1;
    tick();
    bus.weight_array_loaded    = 1'b0;
    bus.activation_L1_loaded   = 1'b0;
    bus.accumulation_L1_loaded = 1'b0;
    check("t3_completion_wins", {bus.start_compute, bus.error, bus.busy}, 3'b101);
    abort_to_idle();

    // Abort in the third FLOW cycle of tile 1 of 2
    start_job(2);
    run_compute(0);
    finish_write();
    check("t4_tile1_idx", bus.tile_idx, 1);
    bus.weight_array_loaded    = 1'b1;
    bus.activation_L1_loaded   = 1'b1;
    bus.accumulation_L1_loaded = 1'b1;
    tick();
    bus.weight_array_loaded    = 1'b0;
    bus.activation_L1_loaded   = 1'b0;
    bus.accumulation_L1_loaded = 1'b0;
    repeat (3) tick();
    check("t4_in_flow", bus.mode, 1);
    ov_snap = n_ov;
    abort_to_idle();
    check("t4_abort_state", {bus.busy, bus.mode, bus.compute_done}, 3'b000);
    repeat (20) tick();
    check("t4_no_more_ov", n_ov, ov_snap);
    start_job(2);
    check("t4_restart_idx", {bus.begin_load, bus.tile_idx}, 4'b1000);
    abort_to_idle();

    // Start gating table
    for (int i = 0; i < 6; i++) begin
      bus.num_tiles            = vecs[i].num_tiles;
      bus.abort                = vecs[i].abort;
      bus.start_multiplication = 1'b1;
      tick();
      bus.start_multiplication = 1'b0;
      bus.abort                = 1'b0;
      check($sformatf("gate_%0d_busy", i), bus.busy, vecs[i].exp_accept);
      check($sformatf("gate_%0d_begin_load", i), bus.begin_load, vecs[i].exp_accept);
      if (bus.busy) abort_to_idle();
    end

    // Starts while busy and a stray L2 pulse in FLOW are ignored
    start_job(1);
    exp_q.push_back(0);
    bus.weight_array_loaded    = 1'b1;
    bus.activation_L1_loaded   = 1'b1;
    bus.accumulation_L1_loaded = 1'b1;
    tick();
    bus.weight_array_loaded    = 1'b0;
    bus.activation_L1_loaded   = 1'b0;
    bus.accumulation_L1_loaded = 1'b0;
    bus.num_tiles              = NT_W'(3);
    bus.start_multiplication   = 1'b1;
    repeat (3) tick();
    bus.output_L2_loaded = 1'b1;
    tick();
    bus.output_L2_loaded = 1'b0;
    repeat (MODE_RUN + 1 - 4) tick();
    bus.start_multiplication = 1'b0;
    check("t5_still_write", {bus.busy, bus.mode, bus.tile_idx}, 5'b10000);
    finish_write();
    check("t5_done", {bus.compute_done, bus.busy}, 2'b10);

    // Async reset in the middle of DRAIN
    start_job(1);
    run_compute(0);
    finish_write();
    start_job(1);
    exp_q.push_back(0);
    bus.weight_array_loaded    = 1'b1;
    bus.activation_L1_loaded   = 1'b1;
    bus.accumulation_L1_loaded = 1'b1;
    tick();
    bus.weight_array_loaded    = 1'b0;
    bus.activation_L1_loaded   = 1'b0;
    bus.accumulation_L1_loaded = 1'b0;
    repeat (K_SCALED + 1 + 3) tick();
    check("t6_in_drain", {bus.busy, bus.mode}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", all_outputs(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_idle_after_release", all_outputs(), 0);
    start_job(1);
    check("t6_restart", {bus.begin_load, bus.busy}, 2'b11);
    run_compute(0);
    finish_write();
    check("t6_done", {bus.compute_done, bus.busy, bus.error}, 3'b100);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vegeta_tiled_control.md
Name: vegeta_tiled_control

Overview:
- Next-generation top-level VEGETA controller. It sequences a runtime-programmable number of weight tiles through load, sync, flow, drain and write-out phases.
- It adds a per-tile index, a synchronous abort, a wait-phase timeout with a sticky error flag, and a busy status.
- It sits above the activation, accumulation, weight, metadata, compute and output control blocks and handshakes with each of them.

Parameters:
- K_SCALED, 4, scaled reduction depth; the flow phase lasts K_SCALED+1 cycles.
- M_SCALED, 4, scaled row count; contributes to the drain length.
- N, 4, array column count; the drain phase lasts N+M_SCALED cycles.
- MAX_TILES, 8, largest tile count per job; must be at least 1.
- TIMEOUT, 256, limit on wait cycles in LOAD or WRITE; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_multiplication  in  1  job request; sampled only in IDLE
- num_tiles  in  clog2(MAX_TILES+1)  tile count; latched when a start is accepted
- abort  in  1  synchronous job cancel
- weight_array_loaded  in  1  single-cycle pulse: weights ready
- activation_L1_loaded  in  1  single-cycle pulse: activations ready
- accumulation_L1_loaded  in  1  single-cycle pulse: accumulators ready
- output_L2_loaded  in  1  single-cycle pulse: tile outputs written
- begin_load  out  1  single-cycle pulse: load the next tile
- start_compute  out  1  single-cycle pulse: compute begins
- mode  out  1  high during flow and drain
- output_valid  out  1  single-cycle pulse: first drain cycle
- tile_idx  out  clog2(MAX_TILES)  index of the current tile
- busy  out  1  high whenever state is not IDLE
- compute_done  out  1  level: the last job completed
- error  out  1  sticky: the last job timed out

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs = 0.
  - All counters and ready flags = 0.
- Output timing: every output is a registered Moore function of the state; there is no combinational input-to-output path.
- IDLE:
  - A start is accepted only if start_multiplication=1 AND 1 <= num_tiles <= MAX_TILES. Any other value is ignored and the block stays in IDLE.
  - On an accepted start: latch num_tiles, set tile_idx=0, clear compute_done and error, go to LOAD.
- LOAD:
  - begin_load=1 in the first LOAD cycle only.
  - Three sticky ready flags (W, A, C) are set by their respective pulses.
  - Define all_ready = (flags OR this cycle's pulses) == 3'b111. Pulses arriving in the same cycle therefore count.
  - When all_ready: clear the flags and go to SYNC.
  - Pulses arriving outside LOAD are ignored.
- SYNC: one cycle; start_compute=1; then go to FLOW.
- FLOW:
  - mode=1 for exactly K_SCALED+1 cycles, counted by flow_cnt from 0 to K_SCALED; then go to DRAIN.
  - flow_cnt width is clog2(K_SCALED+2)+1.
- DRAIN:
  - mode=1 for exactly N+M_SCALED cycles.
  - output_valid=1 in the first DRAIN cycle only.
  - Then go to WRITE.
  - The drain counter width is clog2(N+M_SCALED+1)+1.
- WRITE: on output_L2_loaded:
  - If tile_idx == num_tiles-1: go to IDLE and set compute_done=1. compute_done holds until the next accepted start.
  - Otherwise: increment tile_idx and go to LOAD, which fires begin_load again.
- Total mode-high run per tile: K_SCALED+1+N+M_SCALED contiguous cycles.
- Timeout:
  - wait_cnt resets on entry to LOAD and on entry to WRITE, and increments each cycle spent in either state.
  - If TIMEOUT != 0 and wait_cnt reaches TIMEOUT-1 without the state exiting: set error=1, go to IDLE, leave compute_done=0.
  - If a completion event and the timeout occur in the same cycle, the completion wins.
- abort:
  - In any state other than IDLE: go to IDLE on the next cycle. Counters and flags clear, compute_done stays 0, error is unchanged, and no further pulses are issued.
  - abort outranks every other event in the same cycle.
  - abort in IDLE has no effect, even when a start is presented in that cycle: the start is dropped.
- While busy, start_multiplication is ignored.
- Asynchronous reset mid-job returns the block to the full reset state immediately.

Test Plan:
1. Single tile, timing check. Configuration: K_SCALED=4, M_SCALED=2, N=4, num_tiles=1. Stimulus: start, then all three ready pulses in the same cycle. Expected:
   - begin_load is seen 1 cycle after the start.
   - start_compute follows 1 cycle after the ready cycle.
   - mode is high for 11 cycles.
   - output_valid is high in the 6th mode cycle.
   - After output_L2_loaded: compute_done=1 and busy=0.
2. Three tiles with staggered ready pulses (W at t, A at t+3, C at t+5). Expected:
   - start_compute comes only after C.
   - tile_idx steps 0, 1, 2.
   - Exactly 3 begin_load, 3 start_compute and 3 output_valid pulses.
   - compute_done is set only after the third write.
3. TIMEOUT=16, with accumulation_L1_loaded never asserted. Expected:
   - Return to IDLE 16 cycles after LOAD entry, with error=1, compute_done=0 and no start_compute.
   - A subsequent valid start clears error.
4. Abort asserted in the 3rd FLOW cycle of tile 1 of 2. Expected:
   - Next cycle: busy=0, mode=0, compute_done=0.
   - No further output_valid pulses.
   - tile_idx resets on the next accepted start.
5. Start gating. Stimulus: start with num_tiles=0, then num_tiles=MAX_TILES+1, then start pulses while busy. Expected:
   - Both out-of-range starts are ignored and the block stays in IDLE.
   - Starts while busy have no effect.
   - output_L2_loaded arriving while in FLOW is ignored.
6. Asynchronous reset. Stimulus: rst_n low mid-DRAIN. Expected:
   - All outputs are 0 immediately, without waiting for a clock edge.
   - After release, the block is in IDLE and accepts a fresh start normally.
